// File: rtl/trng_pkg.sv
// Shared types and constants for the entropy collector.
package trng_pkg;

  localparam int DEC_W          = 4;
  localparam int DEF_NUM_OSC    = 4;
  localparam int DEF_WORD_W     = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_DEC_BASE   = 6;
  localparam int DEF_RCT_CUTOFF = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PUSH,
    ST_ALARM
  } trng_state_e;

  typedef enum logic [1:0] {
    VN_DISCARD,
    VN_EMIT0,
    VN_EMIT1
  } vn_outcome_e;

  // Von Neumann pair: 01 -> 0, 10 -> 1, equal pairs carry no entropy.
  function automatic vn_outcome_e vn_resolve(input logic first, input logic second);
    if (first == second) return VN_DISCARD;
    return first ? VN_EMIT1 : VN_EMIT0;
  endfunction

endpackage

// File: rtl/trng_collector_if.sv
// Valid/ready word stream from the collector to the HSM front end.
interface trng_collector_if
  import trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
);
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/trng_fifo.sv
// First-word-fall-through FIFO; head word is presented whenever not empty.
module trng_fifo
  import trng_pkg::*;
#(
  parameter int WIDTH = DEF_WORD_W,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted when the head leaves in the same clock.
  assign do_push = push && (!full || do_pop);
  assign level   = cnt_q;
  assign rdata   = empty ? '0 : mem_q[rd_q];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = wdata;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trng_collector.sv
// Ring-oscillator entropy collector: sync, XOR fold, jittered decimation,
// Von Neumann debias, word packing and FWFT output. Health test: TRNG_RCT_EN.
module trng_collector
  import trng_pkg::*;
#(
  parameter int NUM_OSC    = DEF_NUM_OSC,
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int DEC_BASE   = DEF_DEC_BASE,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_OSC-1:0]          osc_in,
  input  logic                        enable,
  input  logic                        mode,
  input  logic                        req,
  input  logic                        clear,
  trng_collector_if.master            m,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [31:0]                 words_total,
  output logic [15:0]                 overflow_cnt,
  output logic                        busy,
  output logic                        dbg_sample,
  output logic                        dbg_raw,
  output logic                        alarm
);
  localparam int BCW = $clog2(WORD_W+1);

  logic [NUM_OSC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DEC_W-1:0]   cnt_q, cnt_d, thr_q, thr_d;
  logic               sample_q, sample_d;
  logic               have_q, have_d, first_q, first_d;
  logic               vn_strobe_q, vn_strobe_d, vn_bit_q, vn_bit_d;
  logic               req_q, req_d, pend_q, pend_d, req_take;
  trng_state_e        state_q, state_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [BCW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [31:0]        words_q, words_d;
  logic [15:0]        ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;

  assign dbg_raw      = ^sync2_q;
  assign dbg_sample   = sample_q;
  assign busy         = busy_q;
  assign words_total  = words_q;
  assign overflow_cnt = ovf_q;
  assign m.m_valid    = !fifo_empty;
  assign fifo_pop     = m.m_valid && m.m_ready;

  always_comb begin
    sync1_d     = osc_in;
    sync2_d     = sync1_q;
    cnt_d       = '0;
    thr_d       = thr_q;
    sample_d    = 1'b0;
    have_d      = have_q;
    first_d     = first_q;
    vn_strobe_d = 1'b0;
    vn_bit_d    = vn_bit_q;

    if (enable) begin
      if (cnt_q >= thr_q) begin
        thr_d    = DEC_W'(DEC_BASE) + DEC_W'(dbg_raw);
        sample_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (!enable) begin
      have_d = 1'b0;
    end else if (sample_q) begin
      if (!have_q) begin
        have_d  = 1'b1;
        first_d = dbg_raw;
      end else begin
        have_d = 1'b0;
        case (vn_resolve(first_q, dbg_raw))
          VN_EMIT0: begin vn_strobe_d = 1'b1; vn_bit_d = 1'b0; end
          VN_EMIT1: begin vn_strobe_d = 1'b1; vn_bit_d = 1'b1; end
          default:  ;
        endcase
      end
    end

    if (clear) begin
      sync1_d     = '0;
      sync2_d     = '0;
      cnt_d       = '0;
      sample_d    = 1'b0;
      have_d      = 1'b0;
      first_d     = 1'b0;
      vn_strobe_d = 1'b0;
      vn_bit_d    = 1'b0;
    end
  end

`ifdef TRNG_RCT_EN
  localparam int RCW = $clog2(RCT_CUTOFF+1);

  logic [RCW-1:0] rct_cnt_q, rct_cnt_d;
  logic           rct_last_q, rct_last_d, alarm_q, alarm_d;

  always_comb begin
    rct_cnt_d  = rct_cnt_q;
    rct_last_d = rct_last_q;
    alarm_d    = alarm_q;
    if (sample_q) begin
      rct_last_d = dbg_raw;
      if (rct_cnt_q == '0 || dbg_raw != rct_last_q) rct_cnt_d = RCW'(1);
      else if (rct_cnt_q != RCW'(RCT_CUTOFF))       rct_cnt_d = rct_cnt_q + 1'b1;
    end
    if (rct_cnt_d == RCW'(RCT_CUTOFF)) alarm_d = 1'b1;
    if (clear) begin
      rct_cnt_d  = '0;
      rct_last_d = 1'b0;
      alarm_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rct_cnt_q  <= '0;
      rct_last_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      rct_cnt_q  <= rct_cnt_d;
      rct_last_q <= rct_last_d;
      alarm_q    <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_rct;
  assign unused_rct = RCT_CUTOFF[0];
  assign alarm      = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    words_d   = words_q;
    ovf_d     = ovf_q;
    fifo_push = 1'b0;
    req_take  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && (!mode || pend_q)) begin
          state_d  = ST_COLLECT;
          req_take = mode;
        end
      end
      ST_COLLECT: begin
        if (!enable) begin
          state_d   = ST_IDLE;
          acc_d     = '0;
          bit_cnt_d = '0;
        end else if (vn_strobe_q) begin
          acc_d     = {acc_q[WORD_W-2:0], vn_bit_q};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(WORD_W-1)) state_d = ST_PUSH;
        end
      end
      ST_PUSH: begin
        fifo_push = 1'b1;
        acc_d     = '0;
        bit_cnt_d = '0;
        state_d   = (!mode && enable) ? ST_COLLECT : ST_IDLE;
      end
      default: ;
    endcase

`ifdef TRNG_RCT_EN
    if (alarm_q) begin
      state_d   = ST_ALARM;
      fifo_push = 1'b0;
      acc_d     = '0;
      bit_cnt_d = '0;
    end
`endif

    if (fifo_push) begin
      if (fifo_full && !fifo_pop) begin
        if (ovf_q != 16'hFFFF) ovf_d = ovf_q + 1'b1;
      end else begin
        words_d = words_q + 1'b1;
      end
    end

    req_d  = req;
    // Edges arriving while one is pending merge into it.
    pend_d = (pend_q && !req_take) || (req && !req_q);

    if (clear) begin
      state_d   = ST_IDLE;
      acc_d     = '0;
      bit_cnt_d = '0;
      words_d   = '0;
      ovf_d     = '0;
      fifo_push = 1'b0;
      req_d     = 1'b0;
      pend_d    = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      cnt_q       <= '0;
      thr_q       <= DEC_W'(DEC_BASE);
      sample_q    <= 1'b0;
      have_q      <= 1'b0;
      first_q     <= 1'b0;
      vn_strobe_q <= 1'b0;
      vn_bit_q    <= 1'b0;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      bit_cnt_q   <= '0;
      words_q     <= '0;
      ovf_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      thr_q       <= thr_d;
      sample_q    <= sample_d;
      have_q      <= have_d;
      first_q     <= first_d;
      vn_strobe_q <= vn_strobe_d;
      vn_bit_q    <= vn_bit_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      state_q     <= state_d;
      acc_q       <= acc_d;
      bit_cnt_q   <= bit_cnt_d;
      words_q     <= words_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
    end
  end

  trng_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (fifo_push),
    .wdata (acc_q),
    .pop   (fifo_pop),
    .rdata (m.m_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

endmodule
